// File: rtl/parallel_to_serial_pkg.sv
// Shared types and helpers for the parallel-to-serial stream converter.
// The PARALLEL_TO_SERIAL_PARITY_EN build option is handled in the top module.
package parallel_to_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int calc_wb(input int max_w);
        return $clog2(max_w + 1);
    endfunction

    // Zero or oversize widths fall back to a full-width word.
    function automatic int clamp_width(input int w, input int max_w);
        return ((w == 0) || (w > max_w)) ? max_w : w;
    endfunction

endpackage

// File: rtl/parallel_to_serial_stream_if.sv
// Word-side and bit-side handshake bundle for parallel_to_serial_stream.
interface parallel_to_serial_stream_if #(
    parameter int MAX_WIDTH = 16,
    parameter int WB        = $clog2(MAX_WIDTH + 1)
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [MAX_WIDTH-1:0] data;
    logic [WB-1:0]        width;
    logic                 msb_first;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out;
    logic                 out_first;
    logic                 out_last;

    modport master (
        output in_valid, data, width, msb_first, out_ready,
        input  in_ready, out_valid, out, out_first, out_last
    );

    modport slave (
        input  in_valid, data, width, msb_first, out_ready,
        output in_ready, out_valid, out, out_first, out_last
    );
endinterface

// File: rtl/parallel_to_serial_hold.sv
// One-entry skid register for {data, width, msb_first}; write and read may
// coincide in the same cycle, in which case the new word replaces the old.
module parallel_to_serial_hold #(
    parameter int MAX_WIDTH = 16,
    parameter int WB        = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [MAX_WIDTH-1:0] wr_data,
    input  logic [WB-1:0]        wr_width,
    input  logic                 wr_msb,
    output logic                 valid,
    output logic [MAX_WIDTH-1:0] rd_data,
    output logic [WB-1:0]        rd_width,
    output logic                 rd_msb
);
    logic                 valid_q, valid_d;
    logic [MAX_WIDTH-1:0] data_q, data_d;
    logic [WB-1:0]        width_q, width_d;
    logic                 msb_q, msb_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        width_d = width_q;
        msb_d   = msb_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            width_d = wr_width;
            msb_d   = wr_msb;
        end else if (rd_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            width_q <= '0;
            msb_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            width_q <= width_d;
            msb_q   <= msb_d;
        end
    end

    assign valid    = valid_q;
    assign rd_data  = data_q;
    assign rd_width = width_q;
    assign rd_msb   = msb_q;
endmodule

// File: rtl/parallel_to_serial_stream.sv
// Parallel-to-serial converter: shifter, bit counter and bit select in front
// of a one-word hold buffer. `define PARALLEL_TO_SERIAL_PARITY_EN appends an
// even-parity bit to every word.
//
//   state | meaning
//   IDLE  | no word loaded, out_valid low
//   SHIFT | word loaded, cnt selects the bit currently on out
module parallel_to_serial_stream
    import parallel_to_serial_pkg::*;
#(
    parameter int MAX_WIDTH = 16,
    parameter int WB        = calc_wb(MAX_WIDTH)
) (
    input logic                       clock,
    input logic                       reset,
    parallel_to_serial_stream_if.slave bus
);
    localparam logic [MAX_WIDTH-1:0] ONES = '1;

    state_e               state_q, state_d;
    logic [WB-1:0]        cnt_q, cnt_d;
    logic [MAX_WIDTH-1:0] word_q, word_d;
    logic [WB-1:0]        wid_q, wid_d;
    logic                 msb_q, msb_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_q, out_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;

    logic                 hold_valid, hold_wr, hold_rd, hold_msb;
    logic [MAX_WIDTH-1:0] hold_data;
    logic [WB-1:0]        hold_width, in_width, last_idx, last_idx_d, sel_idx;
    logic                 in_ready, in_fire, out_fire, load;
    logic [MAX_WIDTH-1:0] shifted;

    assign in_ready = reset & ~hold_valid;
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;
    assign in_width = WB'(clamp_width(int'(bus.width), MAX_WIDTH));

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    assign last_idx = wid_q;
`else
    assign last_idx = wid_q - WB'(1);
`endif

    assign load = (state_q == IDLE) | (out_fire & (cnt_q == last_idx));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wid_d   = wid_q;
        msb_d   = msb_q;
        hold_rd = 1'b0;
        hold_wr = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (hold_valid) begin
                state_d = SHIFT;
                word_d  = hold_data;
                wid_d   = hold_width;
                msb_d   = hold_msb;
                hold_rd = 1'b1;
                hold_wr = in_fire;
            end else if (in_fire) begin
                state_d = SHIFT;
                word_d  = bus.data;
                wid_d   = in_width;
                msb_d   = bus.msb_first;
            end else begin
                state_d = IDLE;
            end
        end else begin
            hold_wr = in_fire;
            if (out_fire) cnt_d = cnt_q + WB'(1);
        end
    end

    // Output bits are computed from the next shifter contents so they can be registered.
    always_comb begin
        out_valid_d = 1'b0;
        out_d       = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        sel_idx     = msb_d ? (wid_d - WB'(1) - cnt_d) : cnt_d;
        shifted     = word_d >> sel_idx;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        last_idx_d  = wid_d;
`else
        last_idx_d  = wid_d - WB'(1);
`endif
        if (state_d == SHIFT) begin
            out_valid_d = 1'b1;
            first_d     = (cnt_d == '0);
            last_d      = (cnt_d == last_idx_d);
            out_d       = shifted[0];
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
            if (cnt_d == wid_d) out_d = ^(word_d & ~(ONES << wid_d));
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wid_q       <= '0;
            msb_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wid_q       <= wid_d;
            msb_q       <= msb_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    parallel_to_serial_hold #(
        .MAX_WIDTH (MAX_WIDTH),
        .WB        (WB)
    ) u_hold (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (hold_wr),
        .rd_en    (hold_rd),
        .wr_data  (bus.data),
        .wr_width (in_width),
        .wr_msb   (bus.msb_first),
        .valid    (hold_valid),
        .rd_data  (hold_data),
        .rd_width (hold_width),
        .rd_msb   (hold_msb)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Directed bench for parallel_to_serial_stream with hand-computed bit sequences.
module tb_parallel_to_serial_stream;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    parallel_to_serial_stream_if #(.MAX_WIDTH(16)) bus ();

    parallel_to_serial_stream #(.MAX_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail = n_fail + 1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put_word(input logic [15:0] d, input logic [4:0] w, input logic m);
        bus.in_valid  = 1'b1;
        bus.data      = d;
        bus.width     = w;
        bus.msb_first = m;
    endtask

    task automatic chk_bit(input string tag, input logic b, input logic f, input logic l);
        chk_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk_eq({tag, "_out"},   64'(bus.out),       64'(b));
        chk_eq({tag, "_first"}, 64'(bus.out_first), 64'(f));
        chk_eq({tag, "_last"},  64'(bus.out_last),  64'(l));
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [5:0]  exp6;
        logic [3:0]  exp4;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.width     = '0;
        bus.msb_first = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        step();
        chk_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        chk_eq("rst_out",   64'(bus.out),       64'd0);
        chk_eq("rst_first", 64'(bus.out_first), 64'd0);
        chk_eq("rst_last",  64'(bus.out_last),  64'd0);
        chk_eq("rst_ready", 64'(bus.in_ready),  64'd0);
        reset = 1'b1;
        #1;
        chk_eq("rel_ready", 64'(bus.in_ready), 64'd1);
        step();

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        // 0x07 width 3: bits 1,1,1 then even parity 1
        put_word(16'h0007, 5'd3, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bit("par", 1'b1, i == 0, i == 3);
            step();
        end
        chk_eq("par_idle", 64'(bus.out_valid), 64'd0);
`else
        // basic LSB-first 0xA5
        exp8 = 8'b1010_0101;
        put_word(16'h00A5, 5'd8, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_bit("lsb", exp8[i], i == 0, i == 7);
            step();
        end
        chk_eq("lsb_idle", 64'(bus.out_valid), 64'd0);

        // streaming MSB-first 0xC/4 then 0x3/2
        exp6 = 6'b11_0011;
        put_word(16'h000C, 5'd4, 1'b1);
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) put_word(16'h0003, 5'd2, 1'b1);
            if (i == 1) bus.in_valid = 1'b0;
            chk_bit("msb", exp6[5-i], (i == 0) || (i == 4), (i == 3) || (i == 5));
            step();
        end
        chk_eq("msb_idle", 64'(bus.out_valid), 64'd0);

        // stall with back-pressure: 0x96 LSB-first, then 0x0F/4 into hold
        exp8 = 8'h96;
        put_word(16'h0096, 5'd8, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_bit("stl_pre", exp8[i], i == 0, 1'b0);
            step();
        end
        chk_eq("stl_ready0", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
        put_word(16'h000F, 5'd4, 1'b0);
        for (int s = 0; s < 5; s++) begin
            step();
            if (s == 0) put_word(16'hFFFF, 5'd16, 1'b0);
            chk_bit("stl_hold", exp8[2], 1'b0, 1'b0);
            chk_eq("stl_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            chk_bit("stl_w1", exp8[i], 1'b0, i == 7);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk_bit("stl_w2", 1'b1, i == 0, i == 3);
            step();
        end
        chk_eq("stl_idle", 64'(bus.out_valid), 64'd0);

        // width clamp: width 0 then width 20, both become 16
        put_word(16'hFFFF, 5'd0, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            if (i == 0) put_word(16'hFFFF, 5'd20, 1'b1);
            if (i == 1) bus.in_valid = 1'b0;
            chk_bit("clamp", 1'b1, (i == 0) || (i == 16), (i == 15) || (i == 31));
            step();
        end
        chk_eq("clamp_idle", 64'(bus.out_valid), 64'd0);

        // width-1 words stream one per clock through the bypass
        exp4 = 4'b1101;
        put_word(16'h0001, 5'd1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) put_word(16'(exp4[i+1]), 5'd1, 1'b0);
            else bus.in_valid = 1'b0;
            chk_bit("w1", exp4[i], 1'b1, 1'b1);
            chk_eq("w1_ready", 64'(bus.in_ready), 64'd1);
            step();
        end
        chk_eq("w1_idle", 64'(bus.out_valid), 64'd0);

        // reset mid-word with hold full
        exp8 = 8'h5A;
        put_word(16'h005A, 5'd8, 1'b0);
        step();
        put_word(16'h00FF, 5'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_bit("rmw_pre", exp8[i], i == 0, 1'b0);
            step();
            bus.in_valid = 1'b0;
        end
        chk_eq("rmw_full", 64'(bus.in_ready), 64'd0);
        #3;
        reset = 1'b0;
        #1;
        chk_eq("rmw_valid", 64'(bus.out_valid), 64'd0);
        chk_eq("rmw_out",   64'(bus.out),       64'd0);
        chk_eq("rmw_first", 64'(bus.out_first), 64'd0);
        chk_eq("rmw_last",  64'(bus.out_last),  64'd0);
        chk_eq("rmw_ready", 64'(bus.in_ready),  64'd0);
        step();
        reset = 1'b1;
        #1;
        chk_eq("rmw_rel", 64'(bus.in_ready), 64'd1);
        chk_eq("rmw_idle", 64'(bus.out_valid), 64'd0);
        step();
        chk_eq("rmw_nostale", 64'(bus.out_valid), 64'd0);
        put_word(16'h0001, 5'd3, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_bit("rmw_new", i == 2, i == 0, i == 2);
            step();
        end
        chk_eq("rmw_end", 64'(bus.out_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
